// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter sharing one HD44780-style LCD bus between two byte requesters.
// Each granted byte is driven with setup, enable pulse, hold and controller execution delay.
module lcd_bus_arbiter #(
  parameter int T_SETUP = 2,
  parameter int T_EN    = 12,
  parameter int T_CMD   = 2000,
  parameter int T_LONG  = 82000,
  parameter int CNT_W   = 17
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Req_a_valid,
  input  logic       Req_a_rs,
  input  logic [7:0] Req_a_data,
  output logic       Req_a_ready,
  input  logic       Req_b_valid,
  input  logic       Req_b_rs,
  input  logic [7:0] Req_b_data,
  output logic       Req_b_ready,
  output logic       Busy,
  output logic       Grant_b,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DADOS
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    WAIT  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_LONG - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             ptr_b_r;
  logic             sel_b_s;
  logic             accept_s;
  logic             cnt_zero_s;

  // Clear (0x01) and return-home (0x02/0x03) need the long controller execution time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
  endfunction

  assign Busy   = (state_r != IDLE);
  assign LCD_RW = 1'b0;

  // Arbitration, handshake and next-state/counter computation.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    Req_a_ready = 1'b0;
    Req_b_ready = 1'b0;
    sel_b_s     = Req_b_valid & (~Req_a_valid | ptr_b_r);
    cnt_zero_s  = (cnt_r == CNT_ZERO);
    case (state_r)
      IDLE: begin
        if ((Req_a_valid | Req_b_valid) & ~Reset) begin
          accept_s    = 1'b1;
          Req_a_ready = ~sel_b_s;
          Req_b_ready = sel_b_s;
          state_nxt_s = SETUP;
          cnt_nxt_s   = LD_SETUP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETUP: begin
        if (cnt_zero_s) begin
          state_nxt_s = PULSE;
          cnt_nxt_s   = LD_EN;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      PULSE: begin
        if (cnt_zero_s) begin
          state_nxt_s = HOLD;
          cnt_nxt_s   = LD_SETUP;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt_zero_s) begin
          state_nxt_s = WAIT;
          cnt_nxt_s   = is_long_cmd(LCD_RS, LCD_DADOS) ? LD_LONG : LD_CMD;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      WAIT: begin
        if (cnt_zero_s) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // State and delay counter registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Bus pins, owner and priority pointer; EN follows the next state so it is glitch-free.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      LCD_EN    <= 1'b0;
      LCD_RS    <= 1'b0;
      LCD_DADOS <= 8'h00;
      Grant_b   <= 1'b0;
      ptr_b_r   <= 1'b0;
    end else begin
      LCD_EN <= (state_nxt_s == PULSE);
      if (accept_s) begin
        LCD_RS    <= sel_b_s ? Req_b_rs : Req_a_rs;
        LCD_DADOS <= sel_b_s ? Req_b_data : Req_a_data;
        Grant_b   <= sel_b_s;
        ptr_b_r   <= ~sel_b_s;
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Scoreboard bench for lcd_bus_arbiter: a cycle-count reference model predicts grants and
// per-cycle pin values; a separate monitor compares them against the DUT.
module tb_lcd_bus_arbiter;
  localparam int T_SETUP = 2;
  localparam int T_EN    = 12;
  localparam int T_CMD   = 40;
  localparam int T_LONG  = 300;
  localparam int CNT_W   = 17;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Req_a_valid, Req_a_rs, Req_a_ready;
  logic [7:0] Req_a_data;
  logic       Req_b_valid, Req_b_rs, Req_b_ready;
  logic [7:0] Req_b_data;
  logic       Busy, Grant_b, LCD_EN, LCD_RS, LCD_RW;
  logic [7:0] LCD_DADOS;

  lcd_bus_arbiter #(
    .T_SETUP(T_SETUP), .T_EN(T_EN), .T_CMD(T_CMD), .T_LONG(T_LONG), .CNT_W(CNT_W)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .Req_a_valid(Req_a_valid), .Req_a_rs(Req_a_rs), .Req_a_data(Req_a_data), .Req_a_ready(Req_a_ready),
    .Req_b_valid(Req_b_valid), .Req_b_rs(Req_b_rs), .Req_b_data(Req_b_data), .Req_b_ready(Req_b_ready),
    .Busy(Busy), .Grant_b(Grant_b), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_DADOS(LCD_DADOS)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       busy;
    logic       grant_b;
    logic       en;
    logic       rs;
    logic       rw;
    logic [7:0] dados;
  } bus_t;

  typedef struct {
    int cyc;
    bit side_b;
  } acc_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bus_t bus_q[$];
  acc_t acc_q[$];
  logic [8:0] qa[$];
  logic [8:0] qb[$];

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int wait_len(input bit rs, input logic [7:0] d);
    if (!rs && d >= 8'd1 && d <= 8'd3) return T_LONG;
    return T_CMD;
  endfunction

  // Reference model: one transfer occupies 2*T_SETUP+T_EN+wait+1 cycles counted from its accept.
  bit         m_inflight, m_ptr_b, m_rs, m_g, m_busy, m_en, m_wb;
  int         m_c0, m_tot, m_k;
  logic [7:0] m_data;
  initial forever begin
    @(negedge Clock);
    if (Reset) begin
      m_inflight = 0; m_ptr_b = 0; m_rs = 0; m_g = 0; m_data = 8'h00;
      bus_q.delete();
      acc_q.delete();
    end else begin
      m_busy = 0;
      m_en   = 0;
      if (m_inflight) begin
        m_k = cyc - m_c0;
        if (m_k < m_tot) begin
          m_busy = 1;
          m_en   = (m_k > T_SETUP) && (m_k <= T_SETUP + T_EN);
        end else begin
          m_inflight = 0;
        end
      end
      bus_q.push_back({m_busy, m_g, m_en, m_rs, 1'b0, m_data});
      if (!m_busy && (Req_a_valid || Req_b_valid)) begin
        m_wb = Req_b_valid && (!Req_a_valid || m_ptr_b);
        acc_q.push_back('{cyc, m_wb});
        m_rs       = m_wb ? Req_b_rs : Req_a_rs;
        m_data     = m_wb ? Req_b_data : Req_a_data;
        m_g        = m_wb;
        m_ptr_b    = !m_wb;
        m_c0       = cyc;
        m_tot      = 2 * T_SETUP + T_EN + wait_len(m_rs, m_data) + 1;
        m_inflight = 1;
      end
    end
  end

  // Monitor: compares pins every cycle and each handshake against the model's queues.
  bus_t mon_exp;
  acc_t mon_acc;
  initial forever begin
    @(negedge Clock);
    #1;
    if (!Reset) begin
      if (bus_q.size() == 0) begin
        check("bus_q_underflow", 32'd1, 32'd0);
      end else begin
        mon_exp = bus_q.pop_front();
        check("bus_pins", {Busy, Grant_b, LCD_EN, LCD_RS, LCD_RW, LCD_DADOS}, mon_exp);
      end
      if (Req_a_ready || Req_b_ready) begin
        check("ready_exclusive", {31'd0, Req_a_ready & Req_b_ready}, 32'd0);
        if (acc_q.size() == 0) begin
          check("unexpected_ready", {30'd0, Req_b_ready, Req_a_ready}, 32'd0);
        end else begin
          mon_acc = acc_q.pop_front();
          check("accept_cycle", cyc, mon_acc.cyc);
          check("accept_side", {31'd0, Req_b_ready}, {31'd0, mon_acc.side_b});
        end
      end
    end
  end

  // Drives both requesters from qa/qb, holding each payload until it is accepted.
  task automatic run_phase(input bit flaky, input int budget);
    bit acc_a, acc_b;
    int n;
    acc_a = 0; acc_b = 0; n = 0;
    while ((qa.size() > 0 || qb.size() > 0) && n < budget) begin
      @(posedge Clock); #1;
      if (acc_a) void'(qa.pop_front());
      if (acc_b) void'(qb.pop_front());
      Req_a_valid = (qa.size() > 0) && (!flaky || $urandom_range(0, 3) != 0);
      Req_b_valid = (qb.size() > 0) && (!flaky || $urandom_range(0, 3) != 0);
      if (qa.size() > 0) {Req_a_rs, Req_a_data} = qa[0];
      if (qb.size() > 0) {Req_b_rs, Req_b_data} = qb[0];
      @(negedge Clock);
      acc_a = Req_a_valid && Req_a_ready;
      acc_b = Req_b_valid && Req_b_ready;
      n++;
    end
    if (n >= budget) check("phase_timeout", 32'd1, 32'd0);
    Req_a_valid = 1'b0;
    Req_b_valid = 1'b0;
    qa.delete();
    qb.delete();
    n = 0;
    while (Busy && n < budget) begin
      @(negedge Clock);
      n++;
    end
    if (n >= budget) check("idle_timeout", 32'd1, 32'd0);
    repeat (2) @(posedge Clock);
    #1;
  endtask

  function automatic logic [8:0] rnd_byte();
    logic [7:0] d;
    d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
    return {1'($urandom_range(0, 1)), d};
  endfunction

  int acc_c, n;
  initial begin
    Reset = 1'b1;
    Req_a_valid = 1'b1; Req_a_rs = 1'b1; Req_a_data = 8'h55;
    Req_b_valid = 1'b1; Req_b_rs = 1'b0; Req_b_data = 8'hAA;
    repeat (3) @(posedge Clock);
    #1;
    check("reset_outputs", {Busy, Grant_b, LCD_EN, LCD_RS, LCD_RW, LCD_DADOS}, 32'd0);
    check("reset_ready", {30'd0, Req_a_ready, Req_b_ready}, 32'd0);
    Req_a_valid = 1'b0;
    Req_b_valid = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b0;

    // Data byte then normal timing; second byte spacing checks next-accept cycle
    qa.push_back({1'b1, 8'h41}); qa.push_back({1'b1, 8'h42});
    run_phase(1'b0, 5000);
    // Clear/home use long wait, 0x04 short
    qb.push_back({1'b0, 8'h01}); qb.push_back({1'b0, 8'h02});
    qb.push_back({1'b0, 8'h04}); qb.push_back({1'b0, 8'h03});
    run_phase(1'b0, 5000);
    // rs=1 with 0x01 is a character, not clear
    qa.push_back({1'b1, 8'h01}); qa.push_back({1'b0, 8'h01});
    run_phase(1'b0, 5000);
    // Contention: alternating grants
    for (int i = 0; i < 4; i++) begin
      qa.push_back({1'b1, 8'hA0 + 8'(i)});
      qb.push_back({1'b1, 8'hB0 + 8'(i)});
    end
    run_phase(1'b0, 5000);
    // B alone twice, then both: A must win
    qb.push_back({1'b1, 8'h10}); qb.push_back({1'b1, 8'h11});
    run_phase(1'b0, 5000);
    qa.push_back({1'b1, 8'h20}); qb.push_back({1'b1, 8'h21});
    run_phase(1'b0, 5000);

    // Reset in the middle of the enable pulse
    Req_a_rs = 1'b1; Req_a_data = 8'h41; Req_a_valid = 1'b1;
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!Req_a_ready && n < 100);
    if (n >= 100) check("reset_test_accept_timeout", 32'd1, 32'd0);
    acc_c = cyc;
    @(posedge Clock); #1;
    Req_a_valid = 1'b0;
    while (cyc < acc_c + 8) begin
      @(posedge Clock); #1;
    end
    check("en_before_reset", {31'd0, LCD_EN}, 32'd1);
    Reset = 1'b1;
    #1;
    check("reset_mid_pulse", {Busy, Grant_b, LCD_EN, LCD_RS, LCD_RW, LCD_DADOS}, 32'd0);
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;
    qa.push_back({1'b1, 8'h30}); qb.push_back({1'b1, 8'h31});
    run_phase(1'b0, 5000);

    // Randomized traffic with occasional valid drops before grant
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        qa.push_back(rnd_byte());
        qb.push_back(rnd_byte());
      end
      run_phase(1'b1, 20000);
    end

    check("accepts_drained", acc_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
